display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Shares the single 4-digit seven-segment display between three requesters: FSM state readout, event counter and error/status code.
- Round-robin arbitration with a guaranteed minimum dwell time per grant.
- Latches the granted requester's 16-bit payload (four BCD/code nibbles) and presents it as four stable digit codes to the display multiplexer/decoder.
- Codes >9 render as a dash downstream; 4'hF is the blank/dash code.

Parameters:
- DWELL_CYCLES, 8, number of clock cycles a grant owns the display, counted from the ack cycle inclusive; legal range 2..2^24.
- CNT_W, $clog2(DWELL_CYCLES), width of the dwell counter (derived, not overridden).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  3  request per requester; level, held until ack
- req_data  input  48  payloads: requester i on bits [16i+15:16i]; nibble 0 = rightmost digit
- ack  output  3  one-hot, one-cycle pulse: payload of that requester latched
- digit0  output  4  rightmost digit code
- digit1  output  4  digit code
- digit2  output  4  digit code
- digit3  output  4  leftmost digit code
- owner  output  2  index of requester currently shown (0..2)
- valid  output  1  1 once any payload has been latched since reset
- busy  output  1  1 while a dwell is in progress (state SHOW or HOLD)

Behaviour:
Reset values (async, immediate):
- digit0..3 = 4'hF; ack = 0; owner = 0; valid = 0; busy = 0; state = IDLE.
- Round-robin last-grant pointer = 2, so requester 0 wins first.

States: IDLE, SHOW, HOLD.

IDLE:
- busy = 0.
- When req != 0 at a rising edge, arbitrate: first requesting index starting at (last+1) mod 3, wrapping.
- At that edge: digits <= winner's nibbles; owner <= winner; last <= winner; ack[winner] <= 1; valid <= 1; dwell counter <= DWELL_CYCLES-2; go to SHOW.
- Latency: req sampled high at edge t → ack and new digits visible in the cycle following edge t.

SHOW:
- Exactly one cycle; ack is high only in this state.
- Next edge: ack <= 0; go to HOLD.

HOLD:
- Counter decrements each edge.
- At the edge where the counter is 0, the dwell ends (SHOW + HOLD = DWELL_CYCLES cycles total).
- At dwell end, if req != 0, arbitrate exactly as in IDLE and go directly to SHOW (no idle gap); otherwise go to IDLE.

Display and data rules:
- In IDLE the display retains the last latched payload; digits are never blanked except by reset.
- req_data is sampled only at the grant edge; changes during dwell are ignored.
- A req that drops before it is granted is not served and no ack is issued.
- req of the current owner during dwell is ignored until dwell end; it is then treated as any other request.
- A lone repeated requester is re-granted back to back.

Round-robin:
- Pointer wraps 2→0.
- Simultaneous requests are served in rotation; no requester waits more than 2 dwells while continuously requesting.

Reset mid-operation:
- Aborts any dwell; all outputs return to reset values asynchronously.
- A pending ack pulse is cancelled.

Optional Feature:
PREEMPT_EN
- Defined: requester 0 (error code) is a preempting priority channel. If req[0]=1 during SHOW or HOLD while owner != 0, the next edge aborts the dwell and grants requester 0 (ack[0], digits, owner, counter reload, last = 0). Owner-0 dwells are never preempted.
- Undefined: requester 0 is arbitrated round-robin like the others; no dwell is ever shortened.

Test Plan:
- Reset, then req=3'b010, req_data[31:16]=16'h1234 → ack=3'b010 one cycle after sampling; digit3..0 = 1,2,3,4; owner=1; valid=1; busy=1 for 8 cycles, then 0 with digits retained.
- req=3'b111 held, payloads 16'h0001/16'h0002/16'h0003 → acks in order 0,1,2,0 spaced exactly 8 cycles apart, no IDLE cycles between grants.
- Dwell for owner 2, change req_data[47:32] mid-dwell → digits unchanged until the next grant to 2.
- req[1] pulsed high for 1 cycle during owner-0 dwell, then low → no ack[1]; FSM returns to IDLE at dwell end.
- Assert reset in HOLD cycle 3 → digits=4'hF, valid=0, ack=0, busy=0 immediately; the first grant after reset goes to requester 0 when req=3'b111.
- PREEMPT_EN defined, owner=2 in HOLD cycle 2, req[0] rises → next cycle ack[0]=1, owner=0, new 8-cycle dwell. Undefined: ack[0] occurs only at owner-2 dwell end.

Source files
------------

// File: rtl/display_scheduler.sv
// Round-robin scheduler sharing one 4-digit display between three requesters,
// with a guaranteed dwell per grant. Optional macro PREEMPT_EN lets requester 0 preempt.
module display_scheduler #(
    parameter int unsigned DWELL_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [47:0] req_data,
    output logic [2:0]  ack,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [1:0]  owner,
    output logic        valid,
    output logic        busy
);

    localparam int unsigned      CNT_W    = $clog2(DWELL_CYCLES);
    // SHOW consumes one cycle and HOLD ends on the edge after the counter reaches 0.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic [2:0]       ack_q, ack_d;
    logic             valid_q, valid_d;

    logic       rr_hit;
    logic [1:0] rr_win;
    logic       grant;
    logic [1:0] grant_idx;

    // First requester after the last-granted one, wrapping 2 -> 0.
    always_comb begin
        rr_hit = |req;
        rr_win = 2'd0;
        case (last_q)
            2'd0:    rr_win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    rr_win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: rr_win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        ack_d     = 3'b000;
        valid_d   = valid_q;
        grant     = 1'b0;
        grant_idx = rr_win;

        case (state_q)
            IDLE: grant = rr_hit;
            SHOW: state_d = HOLD;
            HOLD: begin
                if (cnt_q == '0) begin
                    if (rr_hit) grant = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PREEMPT_EN
        if ((state_q != IDLE) && req[0] && (owner_q != 2'd0)) begin
            grant     = 1'b1;
            grant_idx = 2'd0;
        end
`endif

        if (grant) begin
            case (grant_idx)
                2'd0: begin digits_d = req_data[15:0];  ack_d = 3'b001; end
                2'd1: begin digits_d = req_data[31:16]; ack_d = 3'b010; end
                default: begin digits_d = req_data[47:32]; ack_d = 3'b100; end
            endcase
            owner_d = grant_idx;
            last_d  = grant_idx;
            cnt_d   = CNT_LOAD;
            valid_d = 1'b1;
            state_d = SHOW;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 2'd2;
            owner_q  <= 2'd0;
            cnt_q    <= '0;
            digits_q <= 16'hFFFF;
            ack_q    <= 3'b000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
        end
    end

    assign ack    = ack_q;
    assign digit0 = digits_q[3:0];
    assign digit1 = digits_q[7:4];
    assign digit2 = digits_q[11:8];
    assign digit3 = digits_q[15:12];
    assign owner  = owner_q;
    assign valid  = valid_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: grants are predicted into a scoreboard
// and checked (requester, payload, owner, cycle) whenever an ack pulse appears.
module tb_display_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] req_data;
    logic [2:0]  ack;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [1:0]  owner;
    logic        valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic [1:0]  o;
        int          c;
    } exp_t;
    exp_t sb[$];

    display_scheduler #(.DWELL_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .owner(owner), .valid(valid), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int idx, input logic [15:0] d, input int c);
        exp_t e;
        e.a = 3'b001 << idx;
        e.d = d;
        e.o = 2'(idx);
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [15:0] digits();
        return {digit3, digit2, digit1, digit0};
    endfunction

    // Scoreboard consumer: every ack pulse must match the oldest prediction.
    always @(negedge clock) begin
        if (ack !== 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {29'd0, ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_onehot", {29'd0, ack}, {29'd0, e.a});
                check("ack_digits", {16'd0, digits()}, {16'd0, e.d});
                check("ack_owner",  {30'd0, owner}, {30'd0, e.o});
                check("ack_cycle",  cyc, e.c);
                check("ack_valid",  {31'd0, valid}, 32'd1);
                check("ack_busy",   {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = 3'b000;
        req_data = 48'd0;
        step(3);
        check("rst_digits", {16'd0, digits()}, 32'hFFFF);
        check("rst_ack",    {29'd0, ack}, 32'd0);
        check("rst_owner",  {30'd0, owner}, 32'd0);
        check("rst_valid",  {31'd0, valid}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step(2);
        check("idle_busy",  {31'd0, busy}, 32'd0);

        // Single request from requester 1; dwell of 8 cycles, then digits retained.
        req = 3'b010;
        req_data[31:16] = 16'h1234;
        expect_grant(1, 16'h1234, cyc + 1);
        step(1);
        req = 3'b000;
        step(7);
        check("t1_busy_last", {31'd0, busy}, 32'd1);
        step(1);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_retained",  {16'd0, digits()}, 32'h1234);
        check("t1_valid",     {31'd0, valid}, 32'd1);

        // Fresh reset so rotation starts at requester 0; all three held.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        req = 3'b111;
        req_data = {16'h0003, 16'h0002, 16'h0001};
        expect_grant(0, 16'h0001, cyc + 1);
        expect_grant(1, 16'h0002, cyc + 9);
        expect_grant(2, 16'h0003, cyc + 17);
        expect_grant(0, 16'h0001, cyc + 25);
        step(1);
        for (int i = 0; i < 24; i++) begin
            step(1);
            check("t2_no_gap", {31'd0, busy}, 32'd1);
        end
        req = 3'b000;
        step(8);
        check("t2_idle_busy", {31'd0, busy}, 32'd0);
        check("t2_digits",    {16'd0, digits()}, 32'h0001);
        check("t2_owner",     {30'd0, owner}, 32'd0);

        // Payload change mid-dwell ignored; lone requester re-granted back to back.
        req = 3'b100;
        req_data[47:32] = 16'hABCD;
        expect_grant(2, 16'hABCD, cyc + 1);
        expect_grant(2, 16'h5678, cyc + 9);
        step(3);
        req_data[47:32] = 16'h5678;
        step(1);
        check("t3_hold_digits", {16'd0, digits()}, 32'hABCD);
        step(5);
        req = 3'b000;
        step(8);
        check("t3_idle_busy", {31'd0, busy}, 32'd0);
        check("t3_digits",    {16'd0, digits()}, 32'h5678);

        // A one-cycle request during another dwell is never served.
        req = 3'b001;
        req_data[15:0] = 16'h0042;
        expect_grant(0, 16'h0042, cyc + 1);
        step(1);
        req = 3'b000;
        step(2);
        req = 3'b010;
        step(1);
        req = 3'b000;
        step(5);
        check("t4_idle_busy", {31'd0, busy}, 32'd0);
        check("t4_owner",     {30'd0, owner}, 32'd0);
        check("t4_digits",    {16'd0, digits()}, 32'h0042);

        // Reset during HOLD cycle 3 clears everything asynchronously.
        req = 3'b010;
        req_data[31:16] = 16'h9999;
        expect_grant(1, 16'h9999, cyc + 1);
        step(1);
        req = 3'b000;
        step(3);
        reset = 1'b1;
        #1;
        check("t5_digits", {16'd0, digits()}, 32'hFFFF);
        check("t5_valid",  {31'd0, valid}, 32'd0);
        check("t5_ack",    {29'd0, ack}, 32'd0);
        check("t5_busy",   {31'd0, busy}, 32'd0);
        check("t5_owner",  {30'd0, owner}, 32'd0);
        step(1);
        reset = 1'b0;
        req = 3'b111;
        req_data = {16'h3333, 16'h2222, 16'h1111};
        expect_grant(0, 16'h1111, cyc + 1);
        step(1);
        req = 3'b000;
        step(8);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);

        // Requester 0 rises while requester 2 owns the display.
        req = 3'b100;
        req_data[47:32] = 16'h7777;
        expect_grant(2, 16'h7777, cyc + 1);
        step(1);
        req = 3'b000;
        step(2);
        req = 3'b001;
        req_data[15:0] = 16'h0E0E;
`ifdef PREEMPT_EN
        expect_grant(0, 16'h0E0E, cyc + 1);
        step(1);
`else
        expect_grant(0, 16'h0E0E, cyc + 6);
        step(1);
        check("t6_no_preempt", {30'd0, owner}, 32'd2);
        step(5);
`endif
        req = 3'b000;
        step(7);
        check("t6_dwell_busy", {31'd0, busy}, 32'd1);
        step(1);
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        check("t6_digits",    {16'd0, digits()}, 32'h0E0E);
        check("t6_owner",     {30'd0, owner}, 32'd0);

        step(2);
        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
